// File: rtl/adder_tree_loader.sv
// -----------------------------------------------------------------------------
// adder_tree_loader
//   Producer side of an adder_tree vector interface. Collects a serial
//   valid/ready sample stream into an N-lane signed vector, launches it into
//   an external adder_tree via tree_data/tree_ena, tracks the tree's fixed
//   pipeline delay with a valid shift register and presents each sum on a
//   valid/ready output. A stalled output freezes the whole tree pipeline.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high
//   s_valid/s_data/s_ready   sample input handshake
//   s_last       short-vector close (only with ADDER_TREE_LOADER_PAD_EN)
//   tree_data    N lanes driven to the tree's data input
//   tree_ena     tree clock enable (low while a sum is stalled)
//   tree_result  sum returned by the tree
//   m_valid/m_sum/m_ready    sum output handshake
//
// Optional feature macro: ADDER_TREE_LOADER_PAD_EN
//   When defined, a sample accepted with s_last=1 closes the vector early and
//   zeroes the remaining upper lanes.
// -----------------------------------------------------------------------------
module adder_tree_loader #(
    parameter int N            = 32,
    parameter int DATA_WIDTH   = 33,
    parameter int RESULT_WIDTH = DATA_WIDTH + $clog2(N) + (((N & (N - 1)) == 0) ? 1 : 0),
    parameter int LATENCY      = $clog2(N)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           s_valid,
    input  logic signed [DATA_WIDTH-1:0]   s_data,
    output logic                           s_ready,
`ifdef ADDER_TREE_LOADER_PAD_EN
    input  logic                           s_last,
`endif
    output logic signed [DATA_WIDTH-1:0]   tree_data [N],
    output logic                           tree_ena,
    input  logic signed [RESULT_WIDTH-1:0] tree_result,
    output logic                           m_valid,
    output logic signed [RESULT_WIDTH-1:0] m_sum,
    input  logic                           m_ready
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

    logic [CW-1:0]                 count_q, count_d;
    logic                          loaded_q, loaded_d;
    logic [LATENCY-1:0]            vpipe_q, vpipe_d;
    logic [LATENCY-1:0]            vshift;
    logic signed [DATA_WIDTH-1:0]  lanes_q [N];
    logic signed [DATA_WIDTH-1:0]  lanes_d [N];
    logic                          accept;
    logic                          close;
    logic                          short_close;

    // Output handshake: a sum waiting on a busy consumer freezes everything.
    assign m_valid  = vpipe_q[LATENCY-1];
    assign m_sum    = tree_result;
    assign tree_ena = !(m_valid && !m_ready);

    // A full vector that cannot launch blocks further samples.
    assign s_ready  = !loaded_q || tree_ena;
    assign accept   = s_valid && s_ready;

`ifdef ADDER_TREE_LOADER_PAD_EN
    assign short_close = s_last;
`else
    assign short_close = 1'b0;
`endif

    assign close = accept && ((count_q == LAST_LANE) || short_close);

    assign tree_data = lanes_q;

    // The vector being marked in the valid pipe is the one the tree samples
    // on this edge, so the launch flag shifts in as loaded_q.
    generate
        if (LATENCY == 1) begin : g_vshift1
            assign vshift = loaded_q;
        end else begin : g_vshiftn
            assign vshift = {vpipe_q[LATENCY-2:0], loaded_q};
        end
    endgenerate

    always_comb begin
        count_d  = count_q;
        loaded_d = loaded_q;
        vpipe_d  = vpipe_q;
        lanes_d  = lanes_q;

        if (tree_ena) begin
            vpipe_d  = vshift;
            loaded_d = 1'b0;
        end

        if (accept) begin
            // Lane 0 may be rewritten on a launch edge; the tree still
            // captures the registered (old) value on that edge.
            if (short_close) begin
                for (int i = 0; i < N; i++) begin
                    if (i > int'(count_q)) begin
                        lanes_d[i] = '0;
                    end
                end
            end
            lanes_d[count_q] = s_data;
            if (close) begin
                count_d  = '0;
                loaded_d = 1'b1;
            end else begin
                count_d  = count_q + 1'b1;
            end
        end
    end

    // Stage p0: lane registers, fill count and launch-valid pipeline
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            loaded_q <= 1'b0;
            vpipe_q  <= '0;
            for (int i = 0; i < N; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            loaded_q <= loaded_d;
            vpipe_q  <= vpipe_d;
            lanes_q  <= lanes_d;
        end
    end

endmodule
